tdm_demux_1to8: RTL and testbench

Time-division 1-to-8 demultiplexer: the receive-side counterpart of the team's 8:1 multiplexer (`D7..D0`, `S2..S0`, `Y`). It takes the single multiplexed stream, recovers slot alignment from a frame-sync marker, and distributes each beat to one of eight channel registers. Complete frames are presented in parallel. It also has a direct-select mode, in which the caller's `S` chooses the channel, mirroring the mux's select inputs.

---
 rtl/tdm_demux_1to8.sv | 207 ++++++++++++++++++++
 tb/tb_tdm_demux_1to8.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1to8
//
// Receive-side time-division demultiplexer. A single multiplexed stream of
// WIDTH-bit beats is split into eight channel slots. In auto mode a slot
// counter, aligned by a frame-sync marker, fills a shadow buffer and the
// whole frame is moved to the parallel output Q once slot 7 arrives. In
// direct mode the caller's S picks the channel for each beat.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   Din         : multiplexed data beat (WIDTH bits)
//   in_valid    : Din carries a beat this cycle
//   sync        : current valid beat is slot 0 (ignored without in_valid)
//   mode        : 0 = auto (slot counter), 1 = direct (S selects channel)
//   S           : channel select for direct mode
//   Q           : eight channel registers, channel i at Q[i*WIDTH +: WIDTH]
//   frame_valid : one-cycle pulse when Q holds a freshly completed frame
//   sync_err    : one-cycle pulse when sync arrived on a nonzero slot
//   slot        : slot index of the next expected beat
//   locked      : high while the auto-mode FSM is in RUN
// ---------------------------------------------------------------------------
module tdm_demux_1to8 #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     Din,
   input  logic                 in_valid,
   input  logic                 sync,
   input  logic                 mode,
   input  logic [2:0]           S,
   output logic [8*WIDTH-1:0]   Q,
   output logic                 frame_valid,
   output logic                 sync_err,
   output logic [2:0]           slot,
   output logic                 locked
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [2:0] LAST_SLOT = 3'd7;

   state_t               r_state;
   state_t               w_stateNext;

   logic [2:0]           r_slot;
   logic [WIDTH-1:0]     r_shadow [0:6];
   logic [8*WIDTH-1:0]   r_q;
   logic                 r_frameValid;
   logic                 r_syncErr;
   logic                 r_locked;

   logic                 w_shadowWe;
   logic [2:0]           w_shadowIdx;
   logic                 w_loadFrame;
   logic                 w_directWe;
   logic                 w_syncErrNext;
   logic [2:0]           w_slotNext;

   // State register. Reset drops the FSM back to IDLE so a fresh sync is
   // needed before any data is accepted again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic. Direct mode parks the FSM in IDLE every cycle, which
   // is what makes a return to auto mode wait for the next sync marker.
   always_comb begin
      w_stateNext = r_state;
      if (mode) begin
         w_stateNext = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && sync) begin
                  w_stateNext = RUN;
               end
            end
            RUN: begin
               w_stateNext = RUN;
            end
            default: begin
               w_stateNext = IDLE;
            end
         endcase
      end
   end

   // Output/control decode. Works out, for the beat on the inputs, where it
   // goes (shadow slot, whole-frame load, or direct channel write), what the
   // slot counter does next, and whether a misplaced sync must be flagged.
   // A sync on slot 0 while running is the normal case and simply restarts
   // at slot 1; a sync anywhere else throws away the partial frame and
   // treats this beat as the new slot 0. The slot-7 beat never lands in the
   // shadow buffer: it goes straight into Q together with slots 0..6.
   always_comb begin
      w_shadowWe    = 1'b0;
      w_shadowIdx   = r_slot;
      w_loadFrame   = 1'b0;
      w_directWe    = 1'b0;
      w_syncErrNext = 1'b0;
      w_slotNext    = r_slot;

      if (mode) begin
         w_directWe = in_valid;
         w_slotNext = 3'd0;
      end else if (in_valid) begin
         case (r_state)
            IDLE: begin
               if (sync) begin
                  w_shadowWe  = 1'b1;
                  w_shadowIdx = 3'd0;
                  w_slotNext  = 3'd1;
               end
            end
            RUN: begin
               if (sync && (r_slot != 3'd0)) begin
                  w_syncErrNext = 1'b1;
                  w_shadowWe    = 1'b1;
                  w_shadowIdx   = 3'd0;
                  w_slotNext    = 3'd1;
               end else if (r_slot == LAST_SLOT) begin
                  w_loadFrame = 1'b1;
                  w_slotNext  = 3'd0;
               end else begin
                  w_shadowWe  = 1'b1;
                  w_shadowIdx = r_slot;
                  w_slotNext  = r_slot + 3'd1;
               end
            end
            default: begin
               w_slotNext = 3'd0;
            end
         endcase
      end
   end

   // Slot counter and status flags. Everything visible outside is taken from
   // a flop so there is no combinational path from inputs to outputs; locked
   // follows the FSM's next state so it changes on the same edge as the beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot       <= 3'd0;
         r_frameValid <= 1'b0;
         r_syncErr    <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_slot       <= w_slotNext;
         r_frameValid <= w_loadFrame;
         r_syncErr    <= w_syncErrNext;
         r_locked     <= (w_stateNext == RUN);
      end
   end

   // Shadow buffer for slots 0..6 of the frame being assembled. Entries are
   // only meaningful once their slot has been written in the current frame,
   // so stale contents after a resync are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 7; i++) begin
            if (w_shadowWe && (w_shadowIdx == 3'(i))) begin
               r_shadow[i] <= Din;
            end
         end
      end
   end

   // Channel registers. A completed auto frame replaces all eight channels
   // at once; a direct-mode beat touches only the channel chosen by S. The
   // two cases are mutually exclusive because they depend on opposite modes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (w_loadFrame) begin
         for (int i = 0; i < 7; i++) begin
            r_q[i*WIDTH +: WIDTH] <= r_shadow[i];
         end
         r_q[7*WIDTH +: WIDTH] <= Din;
      end else if (w_directWe) begin
         for (int i = 0; i < 8; i++) begin
            if (S == 3'(i)) begin
               r_q[i*WIDTH +: WIDTH] <= Din;
            end
         end
      end
   end

   assign Q           = r_q;
   assign frame_valid = r_frameValid;
   assign sync_err    = r_syncErr;
   assign slot        = r_slot;
   assign locked      = r_locked;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1to8
//
// Directed scenarios followed by a randomized run. A behavioural model keeps
// the frame as a plain bit array plus an integer slot position and a locked
// flag, and the DUT outputs are compared against it after every clock edge.
// Key scenario results are also compared against fixed constants.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1to8;

   localparam int W = 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   Din;
   logic           in_valid;
   logic           sync;
   logic           mode;
   logic [2:0]     S;
   logic [8*W-1:0] Q;
   logic           frame_valid;
   logic           sync_err;
   logic [2:0]     slot;
   logic           locked;

   int total = 0;
   int bad   = 0;
   int fvCount = 0;
   int errCount = 0;

   logic [7:0] mQ;
   logic [7:0] mBuf;
   int         mSlot;
   bit         mLocked;
   bit         mFv;
   bit         mErr;

   tdm_demux_1to8 #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Din         (Din),
      .in_valid    (in_valid),
      .sync        (sync),
      .mode        (mode),
      .S           (S),
      .Q           (Q),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .slot        (slot),
      .locked      (locked)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Reference model reset: everything cleared, receiver unlocked.
   task automatic modelReset();
      mQ      = 8'h00;
      mBuf    = 8'h00;
      mSlot   = 0;
      mLocked = 1'b0;
      mFv     = 1'b0;
      mErr    = 1'b0;
   endtask

   // Reference model for one clock edge, written directly from the receive
   // rules: a frame is an 8-entry bit array filled in slot order.
   task automatic modelStep(input logic d, input logic v, input logic sy,
                            input logic md, input logic [2:0] s);
      mFv  = 1'b0;
      mErr = 1'b0;
      if (md) begin
         if (v) mQ[s] = d;
         mLocked = 1'b0;
         mSlot   = 0;
      end else if (v) begin
         if (!mLocked) begin
            if (sy) begin
               mLocked = 1'b1;
               mBuf[0] = d;
               mSlot   = 1;
            end
         end else if (sy && mSlot != 0) begin
            mErr    = 1'b1;
            mBuf[0] = d;
            mSlot   = 1;
         end else begin
            mBuf[mSlot] = d;
            if (mSlot == 7) begin
               mQ    = mBuf;
               mFv   = 1'b1;
               mSlot = 0;
            end else begin
               mSlot = mSlot + 1;
            end
         end
      end
   endtask

   // One comparison point.
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkOutput(input string tag);
      check({tag, "_Q"},           32'(Q),           32'(mQ));
      check({tag, "_frame_valid"}, 32'(frame_valid), 32'(mFv));
      check({tag, "_sync_err"},    32'(sync_err),    32'(mErr));
      check({tag, "_slot"},        32'(slot),        32'(mSlot));
      check({tag, "_locked"},      32'(locked),      32'(mLocked));
   endtask

   // Drive one cycle of inputs on the falling edge, step the model on the
   // rising edge, and check 1 ns after it.
   task automatic applyStimulus(input logic d, input logic v, input logic sy,
                                input logic md, input logic [2:0] s,
                                input string tag);
      @(negedge clk);
      Din      = d;
      in_valid = v;
      sync     = sy;
      mode     = md;
      S        = s;
      @(posedge clk);
      modelStep(d, v, sy, md, s);
      #1;
      checkOutput(tag);
      if (frame_valid) fvCount++;
      if (sync_err) errCount++;
   endtask

   // Send beats firstSlot..lastSlot of a frame (slot i carries val[i]) with
   // sync on slot 0 and an optional idle gap after slot gapAfter.
   task automatic sendFrame(input logic [7:0] val, input int firstSlot,
                            input int lastSlot, input int gapAfter,
                            input int gapLen, input string tag);
      for (int i = firstSlot; i <= lastSlot; i++) begin
         applyStimulus(val[i], 1'b1, (i == 0), 1'b0, 3'd0, tag);
         if (i == gapAfter) begin
            for (int g = 0; g < gapLen; g++) begin
               applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, {tag, "_gap"});
            end
         end
      end
   endtask

   initial begin
      logic [7:0] frames [4];
      frames[0] = 8'h00;
      frames[1] = 8'hA5;
      frames[2] = 8'h5A;
      frames[3] = 8'hFF;

      rst_n    = 1'b0;
      Din      = '0;
      in_valid = 1'b0;
      sync     = 1'b0;
      mode     = 1'b0;
      S        = 3'd0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned frame.
      fvCount = 0;
      sendFrame(8'b01001101, 0, 7, -1, 0, "aligned");
      check("aligned_Qconst",   32'(Q),      32'h4D);
      check("aligned_fvOnce",   32'(fvCount), 32'd1);
      check("aligned_slot0",    32'(slot),   32'd0);
      check("aligned_locked",   32'(locked), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "aligned_after");

      // Back to IDLE through one idle direct-mode cycle, then garbage.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, "toidle");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "garbage");
      end
      check("garbage_unlocked", 32'(locked), 32'd0);
      fvCount = 0;
      sendFrame(8'b01001101, 0, 7, 3, 2, "gapped");
      check("gapped_Qconst", 32'(Q),       32'h4D);
      check("gapped_fvOnce", 32'(fvCount), 32'd1);

      // Early sync at slot 5, then the rest of an all-ones frame.
      errCount = 0;
      sendFrame(8'h00, 0, 4, -1, 0, "early_pre");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, "early_sync");
      check("early_errConst", 32'(sync_err), 32'd1);
      check("early_QKept",    32'(Q),        32'h4D);
      check("early_slot1",    32'(slot),     32'd1);
      sendFrame(8'hFF, 1, 7, -1, 0, "early_post");
      check("early_QFF",      32'(Q),        32'hFF);
      check("early_errOnce",  32'(errCount), 32'd1);

      // Reset in the middle of a frame, checked before the next edge.
      sendFrame(8'h3C, 0, 4, -1, 0, "midrst_pre");
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midrst_async");
      check("midrst_Qzero", 32'(Q), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "midrst_drop");
      end
      check("midrst_unlocked", 32'(locked), 32'd0);

      // Direct mode from Q = 0.
      fvCount = 0;
      errCount = 0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, "direct_s3");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, "direct_idle");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, "direct_s7");
      check("direct_Qconst", 32'(Q),        32'h88);
      check("direct_noFv",   32'(fvCount),  32'd0);
      check("direct_noErr",  32'(errCount), 32'd0);

      // Back-to-back frames at full rate.
      errCount = 0;
      for (int f = 0; f < 4; f++) begin
         fvCount = 0;
         sendFrame(frames[f], 0, 7, -1, 0, "b2b");
         check("b2b_Qconst", 32'(Q),       32'(frames[f]));
         check("b2b_fvOnce", 32'(fvCount), 32'd1);
      end
      check("b2b_noErr", 32'(errCount), 32'd0);

      // Randomized traffic: mostly auto mode, gaps, occasional misplaced
      // sync and occasional direct-mode bursts.
      for (int n = 0; n < 600; n++) begin
         logic rd;
         logic rv;
         logic rs;
         logic rm;
         rd = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rm = ($urandom_range(0, 24) == 0);
         if (mSlot == 0) rs = 1'($urandom);
         else rs = ($urandom_range(0, 15) == 0);
         applyStimulus(rd, rv, rs, rm, 3'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
